// File: rtl/addmul_seq_unit.sv
// ---------------------------------------------------------------------------
// addmul_seq_unit
//   Sequenced signed add / subtract / shift-add multiply engine. One adder is
//   shared by all operations. Its second operand is either the sign-extended
//   B operand (add/sub) or the shifted multiplicand gated by one multiplier
//   bit (multiply). An internal FSM with a start/busy/done handshake drives
//   the sequence.
//
// Ports
//   clk     in   1    rising-edge clock
//   rst_n   in   1    asynchronous active-low reset
//   start   in   1    operation request, sampled only in IDLE
//   op      in   2    00 add, 01 subtract, 10 multiply, 11 reserved (= add)
//   a       in   N    signed operand A (multiplier for multiply)
//   b       in   N    signed operand B (multiplicand for multiply)
//   result  out  2N   signed result register
//   busy    out  1    high while an operation is in progress
//   done    out  1    one-cycle pulse, result valid
// ---------------------------------------------------------------------------
module addmul_seq_unit #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] result,
  output logic           busy,
  output logic           done
);

  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_MUL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    a_ext_s;
  logic [W-1:0]    b_ext_s;
  logic [W-1:0]    pp_s;
  logic            a_bit_s;
  logic            last_iter_s;
  logic [W-1:0]    acc_s;
  logic [W-1:0]    a_in_s;
  logic [W-1:0]    opnd_s;
  logic            sub_s;
  logic [W-1:0]    sum_s;

  assign a_ext_s     = {{N{a_q[N-1]}}, a_q};
  assign b_ext_s     = {{N{b_q[N-1]}}, b_q};
  // Partial product: multiplicand weighted by the current iteration bit.
  assign pp_s        = b_ext_s << cnt_q;
  assign last_iter_s = (cnt_q == CW'(N - 1));

  // Multiplier bit for the current iteration (one-hot compare avoids an
  // over-wide index into a_q).
  always_comb begin
    a_bit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_bit_s = a_q[i];
      end else begin
        a_bit_s = a_bit_s;
      end
    end
  end

  // Adder operand selection: accumulator is 0 for add/sub and the running
  // result for multiply; A only enters during add/sub. The last multiply
  // iteration subtracts because the multiplier MSB carries negative weight.
  always_comb begin
    acc_s  = {W{1'b0}};
    a_in_s = {W{1'b0}};
    opnd_s = {W{1'b0}};
    sub_s  = 1'b0;
    case (state_q)
      S_ADDSUB: begin
        a_in_s = a_ext_s;
        opnd_s = b_ext_s;
        sub_s  = (op_q == 2'b01);
      end
      S_MUL: begin
        acc_s  = result_q;
        opnd_s = a_bit_s ? pp_s : {W{1'b0}};
        sub_s  = last_iter_s;
      end
      default: begin
        acc_s  = {W{1'b0}};
        a_in_s = {W{1'b0}};
        opnd_s = {W{1'b0}};
        sub_s  = 1'b0;
      end
    endcase
  end

  // Shared 2N-bit adder/subtractor; 2N bits cannot overflow for N-bit inputs.
  always_comb begin
    if (sub_s) begin
      sum_s = acc_s + a_in_s - opnd_s;
    end else begin
      sum_s = acc_s + a_in_s + opnd_s;
    end
  end

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          op_d   = op;
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b1;
          if (op == 2'b10) begin
            result_d = {W{1'b0}};
            state_d  = S_MUL;
          end else begin
            state_d  = S_ADDSUB;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDSUB: begin
        result_d = sum_s;
        state_d  = S_DONE;
        done_d   = 1'b1;
      end
      S_MUL: begin
        result_d = sum_s;
        if (last_iter_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= {W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      a_q      <= {N{1'b0}};
      b_q      <= {N{1'b0}};
      op_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_addmul_seq_unit.sv
module tb_addmul_seq_unit;

  logic        clk;
  logic        rst_n;

  logic        start4;
  logic [1:0]  op4;
  logic [3:0]  a4, b4;
  logic [7:0]  result4;
  logic        busy4, done4;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        busy8, done8;

  int n_cmp;
  int n_fail;

  addmul_seq_unit #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .result(result4), .busy(busy4), .done(done4)
  );

  addmul_seq_unit #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .result(result8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step until done4 is seen or the budget runs out; lat counts edges from T0.
  task automatic wait_done4(inout int lat);
    while (done4 !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
  endtask

  // Full single operation on the N=4 unit with all handshake checks.
  task automatic run_check4(input string name, input logic [1:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [7:0] exp_res, input int exp_lat);
    int lat;
    start4 = 1'b1; op4 = op; a4 = a; b4 = b;
    step();
    start4 = 1'b0;
    lat = 1;
    chk({name, "_busy_T0"}, 32'(busy4), 32'd1);
    a4 = ~a; b4 = ~b; op4 = ~op;
    wait_done4(lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, 32'(result4), 32'(exp_res));
    chk({name, "_busy_done"}, 32'(busy4), 32'd0);
    step();
    chk({name, "_done_width"}, 32'(done4), 32'd0);
    chk({name, "_hold"}, 32'(result4), 32'(exp_res));
  endtask

  initial begin
    int lat;
    int ai, bi, ri;
    logic [1:0]  nop;
    logic [7:0]  na, nb;
    logic [15:0] exp16;

    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    start4 = 1'b0; op4 = 2'b00; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'h00; b8 = 8'h00;

    vecs[0] = '{"add_7_m8",    2'b00, 4'h7, 4'h8, 8'hFF, 2};
    vecs[1] = '{"sub_3_m5",    2'b01, 4'h3, 4'hB, 8'h08, 2};
    vecs[2] = '{"rsv_m8_m8",   2'b11, 4'h8, 4'h8, 8'hF0, 2};
    vecs[3] = '{"sub_m8_7",    2'b01, 4'h8, 4'h7, 8'hF1, 2};
    vecs[4] = '{"mul_m8_m8",   2'b10, 4'h8, 4'h8, 8'h40, 5};
    vecs[5] = '{"mul_7_m3",    2'b10, 4'h7, 4'hD, 8'hEB, 5};
    vecs[6] = '{"mul_m1_5",    2'b10, 4'hF, 4'h5, 8'hFB, 5};
    vecs[7] = '{"mul_0_7",     2'b10, 4'h0, 4'h7, 8'h00, 5};
    vecs[8] = '{"mul_7_7",     2'b10, 4'h7, 4'h7, 8'h31, 5};
    vecs[9] = '{"mul_m8_7",    2'b10, 4'h8, 4'h7, 8'hC8, 5};

    #12;
    chk("rst_result4", 32'(result4), 32'd0);
    chk("rst_busy4",   32'(busy4),   32'd0);
    chk("rst_done4",   32'(done4),   32'd0);
    chk("rst_result8", 32'(result8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_no_start", 32'(busy4), 32'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_check4(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
    end

    // Start pulse and operand changes during a multiply are ignored
    start4 = 1'b1; op4 = 2'b10; a4 = 4'h7; b4 = 4'hD;
    step();
    start4 = 1'b0;
    lat = 1;
    step(); lat++;
    start4 = 1'b1; op4 = 2'b00; a4 = 4'h1; b4 = 4'h1;
    step(); lat++;
    start4 = 1'b0;
    wait_done4(lat);
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_res", 32'(result4), 32'hEB);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ign_single_done", 32'(done4), 32'd0);
      chk("ign_not_busy", 32'(busy4), 32'd0);
    end

    // Asynchronous reset in the middle of the 3rd multiply iteration
    start4 = 1'b1; op4 = 2'b10; a4 = 4'h7; b4 = 4'h7;
    step();
    start4 = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(busy4), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result4), 32'd0);
    chk("arst_busy",   32'(busy4),   32'd0);
    chk("arst_done",   32'(done4),   32'd0);
    step();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("arst_no_done", 32'(done4), 32'd0);
    end
    run_check4("after_rst_mul", 2'b10, 4'h6, 4'hD, 8'hEE, 5);

    // N=8 random sweep with back-to-back starts
    nop = 2'($urandom_range(0, 3)); na = 8'($urandom); nb = 8'($urandom);
    start8 = 1'b1; op8 = nop; a8 = na; b8 = nb;
    for (int t = 0; t < 1000; t++) begin
      ai = int'($signed(na));
      bi = int'($signed(nb));
      case (nop)
        2'b01:   ri = ai - bi;
        2'b10:   ri = ai * bi;
        default: ri = ai + bi;
      endcase
      exp16 = ri[15:0];
      step();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (done8 !== 1'b1 && lat < 30) begin
        step();
        lat++;
      end
      chk("rnd_lat", 32'(lat), (nop == 2'b10) ? 32'd9 : 32'd2);
      chk("rnd_res", 32'(result8), 32'(exp16));
      step();
      chk("rnd_done_width", 32'(done8), 32'd0);
      nop = 2'($urandom_range(0, 3)); na = 8'($urandom); nb = 8'($urandom);
      if (t < 999) begin
        start8 = 1'b1; op8 = nop; a8 = na; b8 = nb;
      end else begin
        start8 = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
